// File: rtl/pipe_mux_n.sv
// Registered N-way word selector with valid/ready handshake and a 2-entry skid buffer.
// Out-of-range selects return DEFAULT_VAL with out_err set; flush discards everything held.
module pipe_mux_n #(
  parameter int unsigned             WIDTH       = 32,
  parameter int unsigned             NCH         = 4,
  parameter int unsigned             SELW        = $clog2(NCH),
  parameter logic [WIDTH-1:0]        DEFAULT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [SELW-1:0]       sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_chan,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_chan_q, out_chan_d;
  logic              out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [WIDTH-1:0]  skid_data_q, skid_data_d;
  logic [SELW-1:0]   skid_chan_q, skid_chan_d;
  logic              skid_err_q, skid_err_d;

  logic [WIDTH-1:0]  sel_word;
  logic              sel_err;
  logic              accept;
  logic              consume;

  always_comb begin
    sel_word = DEFAULT_VAL;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_chan_d = skid_chan_q;
    skid_err_d  = skid_err_q;

    // Flush wins over any same-cycle accept; out_data keeps its last value.
    if (flush) begin
      state_d     = EMPTY;
      skid_data_d = '0;
      skid_chan_d = '0;
      skid_err_d  = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            out_data_d = sel_word;
            out_chan_d = sel;
            out_err_d  = sel_err;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_data_d = sel_word;
            out_chan_d = sel;
            out_err_d  = sel_err;
          end else if (accept) begin
            skid_data_d = sel_word;
            skid_chan_d = sel;
            skid_err_d  = sel_err;
            state_d     = TWO;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            out_data_d  = skid_data_q;
            out_chan_d  = skid_chan_q;
            out_err_d   = skid_err_q;
            skid_data_d = '0;
            skid_chan_d = '0;
            skid_err_d  = 1'b0;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      skid_data_q <= '0;
      skid_chan_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      skid_data_q <= skid_data_d;
      skid_chan_q <= skid_chan_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Scoreboard bench for pipe_mux_n: an NCH=4 and an NCH=3 (DEFAULT_VAL=DEADBEEF) instance share stimulus.
// Expected words come from a channel array lookup; a FIFO per instance tracks ordering and occupancy.
module tb_pipe_mux_n;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  c;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ch [4];
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic [127:0] d4;
  logic [95:0]  d3;
  logic         ir0, ov0, oe0, ir1, ov1, oe1;
  logic [31:0]  od0, od1;
  logic [1:0]   oc0, oc1;

  int n_vec = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0_s, e1_s;
  logic acc0_s = 1'b0, acc1_s = 1'b0, fl_s = 1'b0;
  logic stall [2];
  exp_t held [2];

  assign d4 = {ch[3], ch[2], ch[1], ch[0]};
  assign d3 = {ch[2], ch[1], ch[0]};

  always #5 clk = ~clk;

  pipe_mux_n #(.WIDTH(32), .NCH(4), .DEFAULT_VAL(32'h0000_0000)) u_n4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .sel(sel), .in_valid(in_valid),
    .in_ready(ir0), .flush(flush), .out_data(od0), .out_chan(oc0), .out_err(oe0),
    .out_valid(ov0), .out_ready(out_ready)
  );

  pipe_mux_n #(.WIDTH(32), .NCH(3), .DEFAULT_VAL(32'hDEAD_BEEF)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .sel(sel), .in_valid(in_valid),
    .in_ready(ir1), .flush(flush), .out_data(od1), .out_chan(oc1), .out_err(oe1),
    .out_valid(ov1), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [1:0] s, input int nch, input logic [31:0] dflt);
    exp_t r;
    r.c = s;
    if (int'(s) < nch) begin
      r.d = ch[s];
      r.e = 1'b0;
    end else begin
      r.d = dflt;
      r.e = 1'b1;
    end
    return r;
  endfunction

  task automatic mon(input int idx, input logic ov, input logic ir, input logic [31:0] od,
                     input logic [1:0] oc, input logic oe);
    exp_t  e;
    int    sz;
    string nm;
    nm = (idx == 0) ? "n4" : "n3";
    sz = (idx == 0) ? q0.size() : q1.size();
    chk({nm, ".out_valid"}, 64'(ov), 64'(sz > 0));
    chk({nm, ".in_ready"}, 64'(ir), 64'(sz < 2));
    if (stall[idx]) begin
      chk({nm, ".hold_data"}, 64'(od), 64'(held[idx].d));
      chk({nm, ".hold_chan"}, 64'(oc), 64'(held[idx].c));
      chk({nm, ".hold_err"}, 64'(oe), 64'(held[idx].e));
    end
    if (ov && sz > 0) begin
      e = (idx == 0) ? q0[0] : q1[0];
      chk({nm, ".out_data"}, 64'(od), 64'(e.d));
      chk({nm, ".out_chan"}, 64'(oc), 64'(e.c));
      chk({nm, ".out_err"}, 64'(oe), 64'(e.e));
      if (out_ready) begin
        if (idx == 0) void'(q0.pop_front());
        else          void'(q1.pop_front());
      end
    end
    stall[idx]  = ov && !out_ready && !flush;
    held[idx].d = od;
    held[idx].c = oc;
    held[idx].e = oe;
  endtask

  // Monitor: checks outputs mid-cycle and records what the next edge will accept.
  always @(negedge clk) begin
    acc0_s = in_valid && ir0;
    acc1_s = in_valid && ir1;
    fl_s   = flush;
    e0_s   = ref_model(sel, 4, 32'h0000_0000);
    e1_s   = ref_model(sel, 3, 32'hDEAD_BEEF);
    if (!rst_n) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      mon(0, ov0, ir0, od0, oc0, oe0);
      mon(1, ov1, ir1, od1, oc1, oe1);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || fl_s) begin
      q0.delete();
      q1.delete();
    end else begin
      if (acc0_s) q0.push_back(e0_s);
      if (acc1_s) q1.push_back(e1_s);
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    sel       = s;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".n4.out_valid"}, 64'(ov0), 64'(0));
    chk({tag, ".n3.out_valid"}, 64'(ov1), 64'(0));
    chk({tag, ".n4.out_data"}, 64'(od0), 64'(0));
    chk({tag, ".n4.out_chan"}, 64'(oc0), 64'(0));
    chk({tag, ".n4.out_err"}, 64'(oe0), 64'(0));
    chk({tag, ".n4.in_ready"}, 64'(ir0), 64'(1));
    chk({tag, ".n3.in_ready"}, 64'(ir1), 64'(1));
  endtask

  initial begin
    stall[0] = 1'b0;
    stall[1] = 1'b0;
    ch[0] = 32'h1111_1111;
    ch[1] = 32'h2222_2222;
    ch[2] = 32'h3333_3333;
    ch[3] = 32'h4444_4444;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    // Back-to-back stream, sel 0..3 (sel=3 is out of range for the 3-channel instance).
    for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Back-pressure into the skid, then release.
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Flush with two entries held and a concurrent in_valid.
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 1'b1);
    drive(1'b1, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges while streaming.
    drive(1'b1, 2'd1, 1'b1, 1'b0);
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    in_valid = 1'b0;
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Random traffic with changing channel contents.
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 3) != 0, ($urandom % 64) == 0);
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
    end

    for (int i = 0; i < 5; i++) drive(1'b0, 2'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("drain.n4", 64'(q0.size()), 64'(0));
    chk("drain.n3", 64'(q1.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
